// File: rtl/id_inst_queue_if.sv
// IF->ID instruction queue bus: fetch-side push, decode-side pop, branch flush and occupancy.
interface id_inst_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic              flush;
    logic              flush_keep_slot;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush, flush_keep_slot,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush, flush_keep_slot,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/id_inst_queue.sv
// Circular {pc, inst} queue between IF and ID; holds fetched beats across ID stalls and
// trims wrong-path entries on a taken branch, optionally keeping the delay slot.
module id_inst_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    id_inst_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = PC_W + INST_W;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_slot_wait;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ENT_W-1:0] r_head;

    logic             w_enq, w_deq, w_wr_en, w_slot_wait_nxt;
    logic [PTR_W-1:0] w_rd_adv, w_rd_nxt, w_wr_nxt;
    logic [CNT_W-1:0] w_remain, w_count_nxt;
    logic [ENT_W-1:0] w_in_ent, w_head_nxt;

    // Next-state: normal push/pop bookkeeping, overridden by a flush.
    always_comb begin
        w_enq           = bus.in_valid & r_in_ready;
        w_deq           = r_out_valid & bus.out_ready;
        w_in_ent        = {bus.in_pc, bus.in_inst};
        w_rd_adv        = r_rd_ptr + PTR_W'(w_deq);
        w_remain        = r_count - CNT_W'(w_deq);
        w_wr_en         = w_enq;
        w_rd_nxt        = w_rd_adv;
        w_wr_nxt        = r_wr_ptr + PTR_W'(w_enq);
        w_count_nxt     = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        w_slot_wait_nxt = r_slot_wait & ~w_enq;
        w_head_nxt      = '0;

        if (bus.flush) begin
            if (!bus.flush_keep_slot) begin
                w_wr_en         = 1'b0;
                w_rd_nxt        = r_wr_ptr;
                w_wr_nxt        = r_wr_ptr;
                w_count_nxt     = '0;
                w_slot_wait_nxt = 1'b0;
            end else if (w_remain != '0) begin
                // Oldest surviving entry is the delay slot; drop everything behind it.
                w_wr_en         = 1'b0;
                w_rd_nxt        = w_rd_adv;
                w_wr_nxt        = w_rd_adv + PTR_W'(1);
                w_count_nxt     = CNT_W'(1);
                w_slot_wait_nxt = 1'b0;
            end else if (w_enq) begin
                w_wr_en         = 1'b1;
                w_rd_nxt        = r_wr_ptr;
                w_wr_nxt        = r_wr_ptr + PTR_W'(1);
                w_count_nxt     = CNT_W'(1);
                w_slot_wait_nxt = 1'b0;
            end else begin
                w_wr_en         = 1'b0;
                w_rd_nxt        = r_wr_ptr;
                w_wr_nxt        = r_wr_ptr;
                w_count_nxt     = '0;
                w_slot_wait_nxt = 1'b1;
            end
        end

        // Pre-compute the head so out_pc/out_inst come straight from a register.
        if (w_count_nxt != '0) begin
            if (w_wr_en && (w_rd_nxt == r_wr_ptr)) begin
                w_head_nxt = w_in_ent;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_slot_wait <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= '0;
        end else begin
            r_rd_ptr    <= w_rd_nxt;
            r_wr_ptr    <= w_wr_nxt;
            r_count     <= w_count_nxt;
            r_slot_wait <= w_slot_wait_nxt;
            r_in_ready  <= (w_count_nxt < CNT_W'(DEPTH));
            r_out_valid <= (w_count_nxt != '0);
            r_head      <= w_head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_in_ent;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pc    = r_head[ENT_W-1 -: PC_W];
    assign bus.out_inst  = r_head[INST_W-1:0];
    assign bus.count     = r_count;
endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: vector table, directed flush/stall sequences and random traffic
// against a queue-based reference model.
module tb_id_inst_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    id_inst_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) bus ();

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: entries oldest-first, each {pc, inst}.
    logic [63:0] m_q[$];

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        kp;
        int          e_cnt;
        logic        e_valid;
        logic        e_rdy;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t v(input logic r, iv, input logic [31:0] pc, input logic ordy,
                               input int ec, input logic ev, erdy, input logic [31:0] epc);
        vec_t t;
        t.rst = r; t.iv = iv; t.pc = pc; t.ordy = ordy; t.fl = 1'b0; t.kp = 1'b0;
        t.e_cnt = ec; t.e_valid = ev; t.e_rdy = erdy; t.e_pc = epc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, iv, input logic [31:0] pc, inst,
                              input logic ordy, fl, kp);
        logic        acc;
        logic [63:0] ent;
        if (r) begin
            m_q.delete();
        end else begin
            acc = iv && (m_q.size() < DEPTH);
            if (ordy && m_q.size() > 0) void'(m_q.pop_front());
            if (fl) begin
                if (!kp) begin
                    m_q.delete();
                end else if (m_q.size() > 0) begin
                    ent = m_q[0];
                    m_q.delete();
                    m_q.push_back(ent);
                end else if (acc) begin
                    m_q.push_back({pc, inst});
                end
            end else if (acc) begin
                m_q.push_back({pc, inst});
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 64'h0;
        chk({tag, ".count"},     32'(bus.count),     32'(m_q.size()));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(m_q.size() < DEPTH));
        chk({tag, ".out_pc"},    bus.out_pc,         head[63:32]);
        chk({tag, ".out_inst"},  bus.out_inst,       head[31:0]);
    endtask

    // Apply one cycle of inputs, advance the model and the DUT, then compare.
    task automatic drive(input string tag, input logic r, iv, input logic [31:0] pc, inst,
                         input logic ordy, fl, kp);
        rst                 = r;
        bus.in_valid        = iv;
        bus.in_pc           = pc;
        bus.in_inst         = inst;
        bus.out_ready       = ordy;
        bus.flush           = fl;
        bus.flush_keep_slot = kp;
        model_step(r, iv, pc, inst, ordy, fl, kp);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h2400_5A5A;
    endfunction

    task automatic push(input string tag, input logic [31:0] pc);
        drive(tag, 1'b0, 1'b1, pc, inst_of(pc), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive("reset", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
        bus.out_ready = 1'b0; bus.flush = 1'b0; bus.flush_keep_slot = 1'b0;

        // Fill/drain and full-with-dequeue vectors.
        tbl[0]  = v(1, 0, 32'h0,        0, 0, 0, 1, 32'h0);
        tbl[1]  = v(0, 1, 32'hBFC00000, 0, 1, 1, 1, 32'hBFC00000);
        tbl[2]  = v(0, 1, 32'hBFC00004, 0, 2, 1, 1, 32'hBFC00000);
        tbl[3]  = v(0, 1, 32'hBFC00008, 0, 3, 1, 1, 32'hBFC00000);
        tbl[4]  = v(0, 1, 32'hBFC0000C, 0, 4, 1, 0, 32'hBFC00000);
        tbl[5]  = v(0, 1, 32'hBFC00010, 0, 4, 1, 0, 32'hBFC00000);
        tbl[6]  = v(0, 0, 32'h0,        1, 3, 1, 1, 32'hBFC00004);
        tbl[7]  = v(0, 0, 32'h0,        1, 2, 1, 1, 32'hBFC00008);
        tbl[8]  = v(0, 0, 32'h0,        1, 1, 1, 1, 32'hBFC0000C);
        tbl[9]  = v(0, 0, 32'h0,        1, 0, 0, 1, 32'h0);
        tbl[10] = v(0, 0, 32'h0,        1, 0, 0, 1, 32'h0);
        tbl[11] = v(0, 1, 32'h300,      0, 1, 1, 1, 32'h300);
        tbl[12] = v(0, 1, 32'h304,      0, 2, 1, 1, 32'h300);
        tbl[13] = v(0, 1, 32'h308,      0, 3, 1, 1, 32'h300);
        tbl[14] = v(0, 1, 32'h30C,      0, 4, 1, 0, 32'h300);
        tbl[15] = v(0, 1, 32'h310,      1, 3, 1, 1, 32'h304);
        tbl[16] = v(0, 1, 32'h314,      0, 4, 1, 0, 32'h304);
        tbl[17] = v(0, 0, 32'h0,        1, 3, 1, 1, 32'h308);
        tbl[18] = v(0, 0, 32'h0,        1, 2, 1, 1, 32'h30C);
        tbl[19] = v(0, 0, 32'h0,        1, 1, 1, 1, 32'h314);
        tbl[20] = v(0, 0, 32'h0,        1, 0, 0, 1, 32'h0);

        for (int i = 0; i < 21; i++) begin
            drive($sformatf("vec%0d", i), tbl[i].rst, tbl[i].iv, tbl[i].pc,
                  inst_of(tbl[i].pc), tbl[i].ordy, tbl[i].fl, tbl[i].kp);
            chk($sformatf("vec%0d.count", i),     32'(bus.count),     32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d.in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d.out_pc", i),    bus.out_pc,         tbl[i].e_pc);
        end

        // Streaming with pointer wrap: one beat in, one out, every cycle.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive("stream", 1'b0, 1'b1, 32'h1000 + 32'(4 * i), inst_of(32'h1000 + 32'(4 * i)),
                  1'b1, 1'b0, 1'b0);
            chk("stream.count", 32'(bus.count), 32'd1);
            chk("stream.pc", bus.out_pc, 32'h1000 + 32'(4 * i));
        end
        drive("stream_end", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_end.count", 32'(bus.count), 32'd0);

        // Stall hold on a load at the head.
        do_reset();
        drive("stall_lw", 1'b0, 1'b1, 32'h400, 32'h8C220000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive("stall", 1'b0, (i < 3), 32'h404 + 32'(4 * i), inst_of(32'h404 + 32'(4 * i)),
                  1'b0, 1'b0, 1'b0);
            chk("stall.inst", bus.out_inst, 32'h8C220000);
            chk("stall.count", 32'(bus.count), (i < 3) ? 32'(i + 2) : 32'd4);
        end

        // Flush keeping the delay slot, then flush discarding everything.
        for (int k = 1; k >= 0; k--) begin
            do_reset();
            for (int i = 0; i < 4; i++) push("flq", 32'h100 + 32'(4 * i));
            drive("flush", 1'b0, 1'b1, 32'h110, inst_of(32'h110), 1'b1, 1'b1, 1'(k));
            chk("flush.count", 32'(bus.count), 32'(k));
            chk("flush.pc", bus.out_pc, (k == 1) ? 32'h104 : 32'h0);
            drive("flush_after", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("flush_after.count", 32'(bus.count), 32'd0);
        end

        // Delay slot not yet fetched when the branch resolves.
        do_reset();
        push("slot_beq", 32'h200);
        drive("slot_flush", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("slot_flush.count", 32'(bus.count), 32'd0);
        push("slot_fill", 32'h204);
        chk("slot_fill.pc", bus.out_pc, 32'h204);
        chk("slot_fill.count", 32'(bus.count), 32'd1);

        // Delay slot arriving on the flush cycle itself.
        do_reset();
        push("slot2_beq", 32'h200);
        drive("slot2_flush", 1'b0, 1'b1, 32'h204, inst_of(32'h204), 1'b1, 1'b1, 1'b1);
        chk("slot2_flush.pc", bus.out_pc, 32'h204);

        // Reset wins over flush and handshakes.
        do_reset();
        for (int i = 0; i < 3; i++) push("rst_q", 32'h500 + 32'(4 * i));
        drive("rst_mid", 1'b1, 1'b1, 32'h50C, inst_of(32'h50C), 1'b1, 1'b1, 1'b1);
        chk("rst_mid.count", 32'(bus.count), 32'd0);
        chk("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            pc = 32'h8000_0000 + 32'(4 * i);
            drive("rand", ($urandom_range(0, 127) == 0), ($urandom_range(0, 9) < 7), pc,
                  $urandom, ($urandom_range(0, 9) < 5), ($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
